// File: rtl/arm_pkg.sv
// Shared types and widths for the ARM pipeline stages.
package arm_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
      return pc + 32'd4;
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface fetch_stage_if;
   import arm_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline stage register: flush beats freeze, freeze beats load.
module if_id_reg
   import arm_pkg::*;
#(
   parameter int PC_WIDTH   = PC_W,
   parameter int DATA_WIDTH = INSTR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  load,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [DATA_WIDTH-1:0] instr_in,
   output logic [PC_WIDTH-1:0]   pc_ID,
   output logic [DATA_WIDTH-1:0] instr_ID,
   output logic                  valid_ID
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_ID    <= '0;
         instr_ID <= '0;
         valid_ID <= 1'b0;
      end else if (flush) begin
         valid_ID <= 1'b0;
      end else if (!freeze && load) begin
         pc_ID    <= pc_in;
         instr_ID <= instr_in;
         valid_ID <= 1'b1;
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, one-entry skid buffer and FETCH/STALL/DRAIN FSM
// feeding the IF/ID register.
module fetch_stage
   import arm_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_addr,
   fetch_stage_if.master      imem,
   output logic [PC_W-1:0]    pc_ID,
   output logic [INSTR_W-1:0] instr_ID,
   output logic               valid_ID
);
   fetch_state_t       r_state;
   fetch_state_t       w_state_next;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    w_pc_next;
   logic [PC_W-1:0]    w_pc_plus4;
   logic [INSTR_W-1:0] r_skid;
   logic [INSTR_W-1:0] w_skid_next;
   logic               r_skid_valid;
   logic               w_skid_valid_next;
   logic               w_flush;
   logic               w_load;
   logic [INSTR_W-1:0] w_instr_in;

   assign w_pc_plus4     = pc_plus4(r_pc);
   assign imem.imem_req  = !rst && (r_state != STALL);
   assign imem.imem_addr = r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_skid       <= w_skid_next;
         r_skid_valid <= w_skid_valid_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_skid_next       = r_skid;
      w_skid_valid_next = r_skid_valid;
      w_flush           = 1'b0;
      w_load            = 1'b0;
      w_instr_in        = imem.imem_rdata;
      if (branch_taken) begin
         w_pc_next         = branch_addr;
         w_flush           = 1'b1;
         w_skid_valid_next = 1'b0;
         case (r_state)
            FETCH:   w_state_next = imem.imem_ack ? FETCH : DRAIN;
            STALL:   w_state_next = FETCH;
            DRAIN:   w_state_next = DRAIN;
            default: w_state_next = FETCH;
         endcase
      end else begin
         case (r_state)
            FETCH: begin
               if (imem.imem_ack) begin
                  if (freeze) begin
                     w_skid_next       = imem.imem_rdata;
                     w_skid_valid_next = 1'b1;
                     w_state_next      = STALL;
                  end else begin
                     w_load    = 1'b1;
                     w_pc_next = w_pc_plus4;
                  end
               end else if (!freeze) begin
                  w_flush = 1'b1;
               end
            end
            STALL: begin
               // Releasing freeze hands the captured word to ID without a refetch.
               if (!freeze) begin
                  w_state_next      = FETCH;
                  w_skid_valid_next = 1'b0;
                  if (r_skid_valid) begin
                     w_load     = 1'b1;
                     w_instr_in = r_skid;
                     w_pc_next  = w_pc_plus4;
                  end
               end
            end
            DRAIN: begin
               if (imem.imem_ack)
                  w_state_next = FETCH;
            end
            default: w_state_next = FETCH;
         endcase
      end
   end

   if_id_reg #(
      .PC_WIDTH   (PC_W),
      .DATA_WIDTH (INSTR_W)
   ) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .freeze   (freeze),
      .flush    (w_flush),
      .load     (w_load),
      .pc_in    (w_pc_plus4),
      .instr_in (w_instr_in),
      .pc_ID    (pc_ID),
      .instr_ID (instr_ID),
      .valid_ID (valid_ID)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences
// and a randomized run against a transaction-level reference model.
module tb_fetch_stage;
   import arm_pkg::*;

   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [31:0] pc_ID;
   logic [31:0] instr_ID;
   logic        valid_ID;

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (imem_bus),
      .pc_ID        (pc_ID),
      .instr_ID     (instr_ID),
      .valid_ID     (valid_ID)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, sample bus mid-cycle, return 1 after posedge.
   task automatic step(input logic frz, input logic br, input logic [31:0] baddr,
                       input logic ack, input logic [31:0] rdata,
                       output logic req_s, output logic [31:0] addr_s);
      @(negedge clk);
      freeze              = frz;
      branch_taken        = br;
      branch_addr         = baddr;
      imem_bus.imem_ack   = ack;
      imem_bus.imem_rdata = rdata;
      #1;
      req_s  = imem_bus.imem_req;
      addr_s = imem_bus.imem_addr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      freeze = 1'b0; branch_taken = 1'b0;
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
      rst = 1'b1;
      #1;
      chk("rst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
      chk("rst_valid", {31'b0, valid_ID}, 32'd0);
      chk("rst_pc",    pc_ID, 32'd0);
      chk("rst_instr", instr_ID, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rel_req",  {31'b0, imem_bus.imem_req}, 32'd1);
      chk("rel_addr", imem_bus.imem_addr, 32'd0);
   endtask

   typedef struct packed {
      logic        frz;
      logic        br;
      logic [31:0] baddr;
      logic        ack;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs [16];

   // Reference model state: PC, captured-but-undelivered word, abandoned request.
   logic [31:0] m_pc, m_held, m_pc_id, m_instr_id;
   logic        m_held_v, m_stale, m_valid;

   initial begin
      logic        req_s;
      logic [31:0] addr_s;
      logic [31:0] p;
      logic [31:0] tmp;
      logic        frz, br, ack, exp_req;
      logic [31:0] baddr, rdata;

      //             frz   br    baddr         ack   req   addr          valid pc_ID
      vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0,      1'b1, 32'h4};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h4,      1'b1, 32'h8};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h8,      1'b1, 32'hC};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'hC,      1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'hC,      1'b1, 32'h10};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h10,     1'b1, 32'h10};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h10,     1'b1, 32'h10};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h10,     1'b1, 32'h10};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h10,     1'b1, 32'h14};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h14,     1'b1, 32'h18};
      vecs[10] = '{1'b1, 1'b1, 32'h40,      1'b1, 1'b1, 32'h18,     1'b0, 32'h0};
      vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h40,     1'b1, 32'h44};
      vecs[12] = '{1'b0, 1'b1, 32'h100,     1'b0, 1'b1, 32'h44,     1'b0, 32'h0};
      vecs[13] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h100,    1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h100,    1'b0, 32'h0};
      vecs[15] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h100,    1'b1, 32'h104};

      do_reset();

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].frz, vecs[i].br, vecs[i].baddr, vecs[i].ack, vecs[i].eaddr ^ K,
              req_s, addr_s);
         chk($sformatf("vec%0d_req", i),   {31'b0, req_s}, {31'b0, vecs[i].ereq});
         chk($sformatf("vec%0d_addr", i),  addr_s, vecs[i].eaddr);
         chk($sformatf("vec%0d_valid", i), {31'b0, valid_ID}, {31'b0, vecs[i].evalid});
         if (vecs[i].evalid) begin
            chk($sformatf("vec%0d_pc", i),    pc_ID, vecs[i].epc);
            chk($sformatf("vec%0d_instr", i), instr_ID, (vecs[i].epc - 32'd4) ^ K);
         end
         $display("vec %0d: req=%b addr=%h valid_ID=%b pc_ID=%h instr_ID=%h",
                  i, req_s, addr_s, valid_ID, pc_ID, instr_ID);
      end

      // 3-cycle memory: two bubbles per instruction, address held while outstanding.
      p = 32'h104;
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 32'h0, (c == 2), p ^ K, req_s, addr_s);
            chk("lat_req",   {31'b0, req_s}, 32'd1);
            chk("lat_addr",  addr_s, p);
            chk("lat_valid", {31'b0, valid_ID}, (c == 2) ? 32'd1 : 32'd0);
         end
         chk("lat_pc",    pc_ID, p + 32'd4);
         chk("lat_instr", instr_ID, p ^ K);
         $display("latency fetch: addr=%h pc_ID=%h instr_ID=%h", p, pc_ID, instr_ID);
         p = p + 32'd4;
      end

      // Branch to 0x100 while a slow fetch of 0x20 is outstanding.
      step(1'b0, 1'b1, 32'h20, 1'b1, p ^ K, req_s, addr_s);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, req_s, addr_s);
      chk("drn_addr0", addr_s, 32'h20);
      step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, req_s, addr_s);
      chk("drn_valid0", {31'b0, valid_ID}, 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, req_s, addr_s);
      chk("drn_req1",  {31'b0, req_s}, 32'd1);
      chk("drn_addr1", addr_s, 32'h100);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, req_s, addr_s);
      chk("drn_stale_valid", {31'b0, valid_ID}, 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100 ^ K, req_s, addr_s);
      chk("drn_tgt_addr",  addr_s, 32'h100);
      chk("drn_tgt_valid", {31'b0, valid_ID}, 32'd1);
      chk("drn_tgt_pc",    pc_ID, 32'h104);
      chk("drn_tgt_instr", instr_ID, 32'h100 ^ K);
      $display("drain: target pc_ID=%h instr_ID=%h", pc_ID, instr_ID);

      // PC wrap at the top of the address space.
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, req_s, addr_s);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC ^ K, req_s, addr_s);
      chk("wrap_addr",  addr_s, 32'hFFFF_FFFC);
      chk("wrap_pc",    pc_ID, 32'h0);
      chk("wrap_instr", instr_ID, 32'hFFFF_FFFC ^ K);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0 ^ K, req_s, addr_s);
      chk("wrap_next_addr", addr_s, 32'h0);
      chk("wrap_next_pc",   pc_ID, 32'h4);
      $display("wrap: pc_ID=%h instr_ID=%h", pc_ID, instr_ID);

      // Asynchronous reset pulse while in STALL.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678, req_s, addr_s);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, req_s, addr_s);
      chk("stall_req", {31'b0, req_s}, 32'd0);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'b0, valid_ID}, 32'd0);
      chk("arst_pc",    pc_ID, 32'd0);
      chk("arst_instr", instr_ID, 32'd0);
      chk("arst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_rel_addr", imem_bus.imem_addr, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0 ^ K, req_s, addr_s);
      chk("arst_resume_addr",  addr_s, 32'h0);
      chk("arst_resume_pc",    pc_ID, 32'h4);
      chk("arst_resume_instr", instr_ID, 32'h0 ^ K);
      $display("reset mid-stall: resumed pc_ID=%h instr_ID=%h", pc_ID, instr_ID);

      // Randomized run against the reference model.
      do_reset();
      m_pc = 32'h0; m_held = '0; m_held_v = 1'b0; m_stale = 1'b0;
      m_valid = 1'b0; m_pc_id = '0; m_instr_id = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         frz = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 9) == 0);
         tmp = $urandom();
         baddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {tmp[31:2], 2'b00};
         exp_req = !m_held_v;
         ack   = exp_req && ($urandom_range(0, 2) != 0);
         rdata = $urandom();
         freeze = frz; branch_taken = br; branch_addr = baddr;
         imem_bus.imem_ack = ack; imem_bus.imem_rdata = rdata;
         #1;
         chk("rnd_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
         chk("rnd_addr", imem_bus.imem_addr, m_pc);
         @(posedge clk);
         if (br) begin
            m_stale  = exp_req && (m_stale || !ack);
            m_pc     = baddr;
            m_valid  = 1'b0;
            m_held_v = 1'b0;
         end else if (m_stale) begin
            if (ack) m_stale = 1'b0;
         end else if (m_held_v) begin
            if (!frz) begin
               m_pc_id = m_pc + 32'd4; m_instr_id = m_held; m_valid = 1'b1;
               m_pc = m_pc + 32'd4; m_held_v = 1'b0;
            end
         end else if (ack) begin
            if (frz) begin
               m_held = rdata; m_held_v = 1'b1;
            end else begin
               m_pc_id = m_pc + 32'd4; m_instr_id = rdata; m_valid = 1'b1;
               m_pc = m_pc + 32'd4;
            end
         end else if (!frz) begin
            m_valid = 1'b0;
         end
         #1;
         chk("rnd_valid", {31'b0, valid_ID}, {31'b0, m_valid});
         if (m_valid) begin
            chk("rnd_pc",    pc_ID, m_pc_id);
            chk("rnd_instr", instr_ID, m_instr_id);
         end
         if (valid_ID && !(br || frz))
            $display("rnd %0d: pc_ID=%h instr_ID=%h", cyc, pc_ID, instr_ID);
      end

      freeze = 1'b0; branch_taken = 1'b0; imem_bus.imem_ack = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
